// File: rtl/byte_word_loader.sv
// ---------------------------------------------------------------------------
// byte_word_loader
//
// Purpose:
//   Receive side of the byte-serial word path. Bytes arriving on the pins are
//   packed little-endian into 32-bit words, and each finished word is written
//   to the program RAM at an auto-incrementing word address. The host uses
//   this block to preload program/data memory over an 8-bit pin interface.
//
// Parameters:
//   ADDR_WIDTH  word address width; the RAM holds 2**ADDR_WIDTH words
//   START_ADDR  first word address of every load session
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   load_en     session enable (high = loading, low = idle/abort)
//   byte_valid  byte strobe
//   byte_data   byte payload
//   byte_ready  high when a byte offered this cycle will be accepted
//   mem_we      RAM write enable, one-cycle pulse
//   mem_addr    RAM word address
//   mem_wdata   RAM write data
//   word_count  words written this session
//   full        sticky, the last address has been written
//   overflow    sticky, at least one byte was dropped
//
// Optional feature (macro LOADER_PIN_SYNC_EN):
//   When defined, load_en and byte_valid pass through 2-flop synchronizers
//   and byte_valid is rising-edge detected, so each low-to-high transition
//   of the pin counts as exactly one byte. byte_data is sampled in the cycle
//   the edge is detected. This makes the block usable straight from
//   asynchronous pins at the cost of two cycles of input latency.
//   When undefined, inputs are used as they are.
// ---------------------------------------------------------------------------
module byte_word_loader #(
  parameter int          ADDR_WIDTH = 5,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  full,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] START     = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FULL    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;

  logic                  load_in;
  logic                  valid_in;

`ifdef LOADER_PIN_SYNC_EN
  logic [1:0] load_sync_q, load_sync_d;
  logic [1:0] valid_sync_q, valid_sync_d;
  logic       valid_prev_q, valid_prev_d;

  // Two-stage synchronizers; valid_prev holds the synchronized strobe one
  // cycle back so that only a fresh rising edge counts as a byte.
  always_comb begin
    load_sync_d  = {load_sync_q[0], load_en};
    valid_sync_d = {valid_sync_q[0], byte_valid};
    valid_prev_d = valid_sync_q[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_sync_q  <= '0;
      valid_sync_q <= '0;
      valid_prev_q <= 1'b0;
    end else begin
      load_sync_q  <= load_sync_d;
      valid_sync_q <= valid_sync_d;
      valid_prev_q <= valid_prev_d;
    end
  end

  assign load_in  = load_sync_q[1];
  assign valid_in = valid_sync_q[1] & ~valid_prev_q;
`else
  assign load_in  = load_en;
  assign valid_in = byte_valid;
`endif

  // Next-state logic. A falling load_en in COLLECT wins over a byte in the
  // same cycle, so a 4th byte arriving together with the abort is dropped
  // without a write. Bytes offered while not ready (WRITE/FULL) only set the
  // sticky overflow flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    full_d  = full_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (load_in) begin
          state_d = COLLECT;
          addr_d  = START;
          count_d = '0;
          full_d  = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = 2'd0;
        end
      end

      COLLECT: begin
        if (!load_in) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else if (valid_in) begin
          wdata_d[8*idx_q +: 8] = byte_data;
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = WRITE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      WRITE: begin
        if (valid_in) begin
          ovf_d = 1'b1;
        end
        count_d = count_q + COUNT_ONE;
        if (addr_q == LAST_ADDR) begin
          full_d  = 1'b1;
          state_d = load_in ? FULL : IDLE;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = load_in ? COLLECT : IDLE;
        end
      end

      FULL: begin
        if (valid_in) begin
          ovf_d = 1'b1;
        end
        if (!load_in) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The write strobe is registered: it is high exactly while in WRITE.
    mem_we_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      mem_we_q <= 1'b0;
      addr_q   <= START;
      wdata_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign byte_ready = (state_q == COLLECT);
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign full       = full_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_byte_word_loader.sv
// ---------------------------------------------------------------------------
// tb_byte_word_loader
//
// Self-checking bench for byte_word_loader in its default build
// (ADDR_WIDTH = 5, START_ADDR = 0, pin synchronizer disabled).
// Expected RAM writes are queued when the 4th byte of a word is driven and
// popped by a monitor whenever the DUT pulses mem_we.
// ---------------------------------------------------------------------------
module tb_byte_word_loader;

  localparam int ADDR_WIDTH = 5;

  logic                  clk;
  logic                  rst;
  logic                  load_en;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  full;
  logic                  overflow;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
  } exp_write_t;

  exp_write_t expQueue[$];

  int checks;
  int errors;
  int writesSeen;
  int writesExpected;

  byte_word_loader #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .START_ADDR(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .full       (full),
    .overflow   (overflow)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of byte interface stimulus on the falling edge.
  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    @(negedge clk);
    byte_valid = valid;
    byte_data  = data;
  endtask

  // Sends one word as four bytes, queueing the expected write when the
  // last byte is driven. Optional random idle gaps between bytes.
  task automatic sendWord(input logic [ADDR_WIDTH-1:0] addr,
                          input logic [31:0] word, input bit gaps,
                          input bit expectWrite);
    exp_write_t e;
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b1, word[8*b +: 8]);
      if (b == 3 && expectWrite) begin
        e.addr = addr;
        e.data = word;
        expQueue.push_back(e);
        writesExpected++;
      end
      if (gaps && b != 3) begin
        int n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) applyStimulus(1'b0, 8'h00);
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic startSession();
    @(negedge clk);
    load_en    = 1'b1;
    byte_valid = 1'b0;
  endtask

  task automatic endSession();
    @(negedge clk);
    load_en    = 1'b0;
    byte_valid = 1'b0;
  endtask

  // Scoreboard monitor: every write pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_write_t e;
    if (mem_we === 1'b1) begin
      writesSeen++;
      if (expQueue.size() == 0) begin
        checkOutput("spurious_we", 32'(mem_we), 32'd0);
      end else begin
        e = expQueue.pop_front();
        checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
        checkOutput("wr_data", mem_wdata, e.data);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] word;
    checks         = 0;
    errors         = 0;
    writesSeen     = 0;
    writesExpected = 0;
    rst        = 1'b1;
    load_en    = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Reset values
    #12;
    checkOutput("rst_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_count", 32'(word_count), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic word: 78 56 34 12 -> 0x12345678 at address 0
    $display("[TB] basic word");
    startSession();
    @(negedge clk);
    checkOutput("collect_ready", 32'(byte_ready), 32'd1);
    byte_valid = 1'b1;
    byte_data  = 8'h78;
    applyStimulus(1'b1, 8'h56);
    applyStimulus(1'b1, 8'h34);
    applyStimulus(1'b1, 8'h12);
    expQueue.push_back('{addr: 5'd0, data: 32'h12345678});
    writesExpected++;
    applyStimulus(1'b0, 8'h00);
    checkOutput("write_ready", 32'(byte_ready), 32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("basic_count", 32'(word_count), 32'd1);
    checkOutput("basic_addr", 32'(mem_addr), 32'd1);
    checkOutput("basic_ovf", 32'(overflow), 32'd0);

    // Results held in IDLE, then back-to-back bytes with one dropped
    $display("[TB] held valid with drop");
    endSession();
    @(negedge clk);
    checkOutput("idle_hold_count", 32'(word_count), 32'd1);
    checkOutput("idle_ready", 32'(byte_ready), 32'd0);
    load_en = 1'b1;
    @(negedge clk);
    checkOutput("restart_count", 32'(word_count), 32'd0);
    checkOutput("restart_addr", 32'(mem_addr), 32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'h01;
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'h03);
    applyStimulus(1'b1, 8'h04);
    expQueue.push_back('{addr: 5'd0, data: 32'h04030201});
    writesExpected++;
    applyStimulus(1'b1, 8'h05);
    checkOutput("drop_ready", 32'(byte_ready), 32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("drop_ovf", 32'(overflow), 32'd1);
    checkOutput("drop_count", 32'(word_count), 32'd1);

    // Fill the whole memory with gapped bytes, then overrun
    $display("[TB] fill memory");
    endSession();
    startSession();
    @(negedge clk);
    checkOutput("fill_ovf_cleared", 32'(overflow), 32'd0);
    for (int w = 0; w < 32; w++) begin
      word = $urandom;
      sendWord(5'(w), word, 1'b1, 1'b1);
      idleCycles(1 + $urandom_range(0, 1));
    end
    idleCycles(1);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_count", 32'(word_count), 32'd32);
    checkOutput("fill_addr", 32'(mem_addr), 32'd31);
    checkOutput("fill_ready", 32'(byte_ready), 32'd0);
    checkOutput("fill_ovf", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 8'h99);
    applyStimulus(1'b0, 8'h00);
    checkOutput("overrun_ovf", 32'(overflow), 32'd1);
    checkOutput("overrun_count", 32'(word_count), 32'd32);
    idleCycles(2);

    // Aborted partial word is discarded
    $display("[TB] abort partial word");
    endSession();
    startSession();
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    endSession();
    startSession();
    sendWord(5'd0, 32'hDDCCBBAA, 1'b0, 1'b1);
    idleCycles(2);
    checkOutput("abort_ovf", 32'(overflow), 32'd0);
    checkOutput("abort_count", 32'(word_count), 32'd1);
    checkOutput("abort_full", 32'(full), 32'd0);

    // Asynchronous reset during the WRITE cycle of the second word
    $display("[TB] async reset in write");
    endSession();
    startSession();
    sendWord(5'd0, 32'hCAFEF00D, 1'b0, 1'b1);
    idleCycles(2);
    sendWord(5'd1, 32'h0BADBEEF, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst        = 1'b1;
    load_en    = 1'b0;
    byte_valid = 1'b0;
    #1;
    checkOutput("arst_we", 32'(mem_we), 32'd0);
    checkOutput("arst_addr", 32'(mem_addr), 32'd0);
    checkOutput("arst_count", 32'(word_count), 32'd0);
    checkOutput("arst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idleCycles(6);

    checkOutput("write_total", 32'(writesSeen), 32'(writesExpected));
    checkOutput("queue_empty", 32'(expQueue.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
